// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid read, result held for decode.
// Optional stall counter output o_stall_cnt is enabled by defining IFU_PERF_CNT_EN.
module ifetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RST_INST = 32'h0000_0013,
  parameter int unsigned PERF_W   = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_pc_en,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [PERF_W-1:0] o_stall_cnt,
`endif
  input  logic            i_id_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] req_pc;
  logic            discard;

  // Request and PC-advance strobes; pc_en is gated off in reset and IDLE
  always_comb begin
    o_imem_req  = (state == S_REQ) && !i_flush;
    o_imem_addr = {i_pc[XLEN-1:2], 2'b00};
    o_pc_en     = i_rst_n && (state != S_IDLE) &&
                  (((state == S_HOLD) && i_id_ready) || i_flush);
  end

  // Fetch FSM with held-instruction registers and stale-response discard
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_inst_valid <= 1'b0;
      o_inst       <= RST_INST;
      o_inst_pc    <= '0;
      req_pc       <= '0;
      discard      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (!i_flush && i_imem_gnt) begin
            req_pc <= i_pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            if (discard || i_flush) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              o_inst       <= i_imem_rdata;
              o_inst_pc    <= req_pc;
              o_inst_valid <= 1'b1;
              state        <= S_HOLD;
            end
          end else if (i_flush) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_flush || i_id_ready) begin
            o_inst_valid <= 1'b0;
            state        <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating count of active cycles without an instruction ready
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if ((state != S_IDLE) && !o_inst_valid &&
                 (o_stall_cnt != {PERF_W{1'b1}})) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: scripted memory, scoreboard on o_inst_valid rise.
// Define IFU_PERF_CNT_EN to also exercise the stall counter (PERF_W=4).
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        flush;
  logic        pc_en;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ivalid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready;
`ifdef IFU_PERF_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_unit #(
    .XLEN(32),
    .RST_INST(32'h0000_0013),
    .PERF_W(4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pc(pc),
    .i_flush(flush),
    .o_pc_en(pc_en),
    .o_imem_req(req),
    .o_imem_addr(addr),
    .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata),
    .o_inst_valid(ivalid),
    .o_inst(inst),
    .o_inst_pc(inst_pc),
`ifdef IFU_PERF_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .i_id_ready(ready)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every new presentation of an instruction must match the queue head
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n && ivalid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst", inst, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e[63:32]);
        chk("sb_pc", inst_pc, e[31:0]);
      end
    end
    prev_valid <= rst_n && ivalid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int reqs;
    logic [31:0] held;
    rst_n = 1'b0; pc = 32'h0; flush = 1'b1; gnt = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; ready = 1'b0;
    repeat (3) tick();
    settle();
    chk("rst_valid", {31'b0, ivalid}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_pc_en_flush", {31'b0, pc_en}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
`endif
    // 1: IDLE one cycle, then zero-wait fetch at 0x0
    flush = 1'b0;
    rst_n = 1'b1;
    settle();
    chk("idle_req", {31'b0, req}, 32'd0);
    chk("idle_pc_en", {31'b0, pc_en}, 32'd0);
    tick();
    gnt = 1'b1;
    exp_q.push_back({32'h0050_0093, 32'h0});
    settle();
    chk("t1_req", {31'b0, req}, 32'd1);
    chk("t1_addr", addr, 32'h0);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
    settle();
    chk("t1_wait_req", {31'b0, req}, 32'd0);
    chk("t1_wait_valid", {31'b0, ivalid}, 32'd0);
    tick();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    // 2: decode stalls five cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t2_valid", {31'b0, ivalid}, 32'd1);
      chk("t2_inst", inst, 32'h0050_0093);
      chk("t2_inst_pc", inst_pc, 32'h0);
      chk("t2_req", {31'b0, req}, 32'd0);
      chk("t2_pc_en", {31'b0, pc_en}, 32'd0);
      tick();
    end
    ready = 1'b1;
    settle();
    chk("t1_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    ready = 1'b0; pc = 32'h104;
    settle();
    chk("t1_pc_en_once", {31'b0, pc_en}, 32'd0);
    chk("t1_valid_clr", {31'b0, ivalid}, 32'd0);
    // 3: grant delayed three cycles, address stable, one transaction
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (req) reqs++;
      chk("t3_addr", addr, 32'h104);
      tick();
    end
    gnt = 1'b1;
    exp_q.push_back({32'h0010_0113, 32'h104});
    settle();
    if (req) reqs++;
    chk("t3_addr_gnt", addr, 32'h104);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0113;
    settle();
    if (req) reqs++;
    chk("t3_req_cycles", reqs, 32'd4);
    tick();
    rvalid = 1'b0; ready = 1'b1;
    settle();
    chk("t3_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    ready = 1'b0; pc = 32'h108;
    // 4: flush in WAIT, late response dropped, refetch from new PC
    gnt = 1'b1;
    tick();
    gnt = 1'b0; flush = 1'b1;
    settle();
    chk("t4_pc_en", {31'b0, pc_en}, 32'd1);
    chk("t4_req", {31'b0, req}, 32'd0);
    tick();
    flush = 1'b0; pc = 32'h200;
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    settle();
    chk("t4_valid", {31'b0, ivalid}, 32'd0);
    chk("t4_req2", {31'b0, req}, 32'd1);
    chk("t4_addr", addr, 32'h200);
    // 5a: flush and rvalid together
    gnt = 1'b1;
    tick();
    gnt = 1'b0; flush = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0BAD;
    settle();
    chk("t5a_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    flush = 1'b0; rvalid = 1'b0; pc = 32'h300;
    settle();
    chk("t5a_valid", {31'b0, ivalid}, 32'd0);
    chk("t5a_req", {31'b0, req}, 32'd1);
    chk("t5a_pc_en_once", {31'b0, pc_en}, 32'd0);
    // flush in REQ suppresses the request and stays put
    flush = 1'b1; gnt = 1'b1;
    settle();
    chk("req_flush_req", {31'b0, req}, 32'd0);
    chk("req_flush_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    flush = 1'b0;
    exp_q.push_back({32'h00A0_0113, 32'h300});
    settle();
    chk("req_flush_stay", {31'b0, req}, 32'd1);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00A0_0113;
    tick();
    rvalid = 1'b0;
    // 5b: flush with ready in HOLD
    flush = 1'b1; ready = 1'b1;
    settle();
    chk("t5b_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    flush = 1'b0; ready = 1'b0; pc = 32'h400;
    settle();
    chk("t5b_valid", {31'b0, ivalid}, 32'd0);
    chk("t5b_req", {31'b0, req}, 32'd1);
    chk("t5b_pc_en_once", {31'b0, pc_en}, 32'd0);
    // reset mid-transaction; the late response must be ignored
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    settle();
    chk("rst_mid_valid", {31'b0, ivalid}, 32'd0);
    chk("rst_mid_inst", inst, 32'h0000_0013);
    chk("rst_mid_req", {31'b0, req}, 32'd1);
`ifdef IFU_PERF_CNT_EN
    // 6: long grant stall saturates the 4-bit counter
    for (int i = 0; i < 20; i++) tick();
    settle();
    chk("t6_sat", {28'b0, stall_cnt}, 32'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("t6_rst", {28'b0, stall_cnt}, 32'h0);
`endif
    held = exp_q.size();
    chk("sb_drained", held, 32'd0);
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
